// File: rtl/vc_buffer.sv
// vc_buffer: per-VC input flit FIFO with occupancy/packet counts for link-level flow control.
// Optional sticky overflow/underflow flags are built when VC_BUF_ERR_EN is defined.
module vc_buffer #(
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0,
  parameter int VCHID    = 0,
  parameter int DEPTH    = 4,
  parameter int DATAW    = 32,
  parameter int TYPE_MSB = DATAW,
  parameter int TYPE_LSB = DATAW - 2,
  parameter logic [TYPE_MSB-TYPE_LSB:0] FT_TAIL     = 'd3,
  parameter logic [TYPE_MSB-TYPE_LSB:0] FT_HEADTAIL = 'd4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en_i,
  input  logic [DATAW:0] wr_data_i,
  output logic           rdy_o,
  output logic [DATAW:0] rd_data_o,
  output logic           vld_o,
  input  logic           send_i,
  output logic [CW-1:0]  count_o,
  output logic [CW-1:0]  pkt_o,
  output logic           ovf_o,
  output logic           udf_o
);
  if (ROUTERID < 0 || PCHID < 0 || VCHID < 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("vc_buffer R%0d P%0d V%0d: DEPTH %0d must be a power of two >= 2", ROUTERID, PCHID, VCHID, DEPTH);
  end
  logic [DATAW:0] mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d, pkt_q, pkt_d;
  logic [DATAW:0] head;
  logic           full, empty, push, pop, wr_pkt_end, rd_pkt_end;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign push  = wr_en_i && !full;
  assign pop   = send_i && !empty;
  assign head  = mem_q[rd_ptr_q];
  assign wr_pkt_end = wr_data_i[TYPE_MSB:TYPE_LSB] == FT_TAIL || wr_data_i[TYPE_MSB:TYPE_LSB] == FT_HEADTAIL;
  assign rd_pkt_end = head[TYPE_MSB:TYPE_LSB] == FT_TAIL || head[TYPE_MSB:TYPE_LSB] == FT_HEADTAIL;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    pkt_d    = pkt_q + CW'(push && wr_pkt_end) - CW'(pop && rd_pkt_end);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pkt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pkt_q    <= pkt_d;
    end
  // Storage needs no reset: reads are masked by the occupancy count.
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  assign rdy_o     = !full;
  assign vld_o     = !empty;
  assign rd_data_o = empty ? '0 : head;
  assign count_o   = count_q;
  assign pkt_o     = pkt_q;
`ifdef VC_BUF_ERR_EN
  logic ovf_q, udf_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_en_i && full) ovf_q <= 1'b1;
      if (send_i && empty && !wr_en_i) udf_q <= 1'b1;
    end
`ifndef SYNTHESIS
  always @(posedge clk)
    if (rst_n) begin
      if (wr_en_i && full) $error("vc_buffer R%0d P%0d V%0d: overflow, flit dropped", ROUTERID, PCHID, VCHID);
      if (send_i && empty && !wr_en_i) $error("vc_buffer R%0d P%0d V%0d: underflow", ROUTERID, PCHID, VCHID);
    end
`endif
  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`else
  assign ovf_o = 1'b0;
  assign udf_o = 1'b0;
`endif
endmodule

// File: tb/tb_vc_buffer.sv
// tb_vc_buffer: queue-model checker plus directed vectors for vc_buffer (DEPTH=4, DATAW=32).
module tb_vc_buffer;
  localparam logic [2:0] HEAD = 3'd1, BODY = 3'd2, TAIL = 3'd3, HT = 3'd4;
  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, send = 1'b0;
  logic [32:0] wr_data = '0, rd_data;
  logic rdy, vld, ovf, udf;
  logic [2:0] cnt, pkt;
  int checks = 0, errors = 0;
  logic [32:0] model_q[$];
  logic [32:0] obs_q[$];
  bit streaming = 1'b0;
  vc_buffer dut (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data), .rdy_o(rdy),
    .rd_data_o(rd_data), .vld_o(vld), .send_i(send), .count_o(cnt), .pkt_o(pkt),
    .ovf_o(ovf), .udf_o(udf)
  );
  always #5 clk = ~clk;
  function automatic logic [32:0] fl(logic [2:0] t, logic [29:0] p);
    return {t, p};
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(bit we, logic [32:0] d, bit s);
    @(posedge clk);
    #2;
    wr_en = we;
    wr_data = d;
    send = s;
  endtask
  // Reference: a FIFO of at most 4 flits; the full/empty tests use pre-edge occupancy.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) model_q.delete();
    else begin
      automatic bit do_push = wr_en && model_q.size() < 4;
      automatic bit do_pop  = send && model_q.size() > 0;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(wr_data);
    end
  always @(negedge clk) begin
    automatic int n = model_q.size();
    automatic int p = 0;
    foreach (model_q[i]) if (model_q[i][32:30] == TAIL || model_q[i][32:30] == HT) p++;
    chk("count", 64'(cnt), 64'(n));
    chk("pkt", 64'(pkt), 64'(p));
    chk("vld", 64'(vld), 64'(n != 0));
    chk("rdy", 64'(rdy), 64'(n < 4));
    chk("rd_data", 64'(rd_data), n != 0 ? 64'(model_q[0]) : 64'd0);
    chk("ovf_udf", {62'd0, ovf, udf}, 64'd0);
    if (streaming) begin
      chk("stream_count_le1", 64'(cnt <= 3'd1), 64'd1);
      if (vld && send) obs_q.push_back(rd_data);
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(0, '0, 0);
    @(negedge clk);
    chk("t1_vld", 64'(vld), 64'd0);
    chk("t1_rdy", 64'(rdy), 64'd1);
    chk("t1_count", 64'(cnt), 64'd0);
    chk("t1_rd_data", 64'(rd_data), 64'd0);
    cyc(1, fl(HEAD, 30'h11), 0);
    cyc(1, fl(BODY, 30'h22), 0);
    cyc(1, fl(TAIL, 30'h33), 0);
    cyc(0, '0, 0);
    @(negedge clk);
    chk("t2_count", 64'(cnt), 64'd3);
    chk("t2_pkt", 64'(pkt), 64'd1);
    chk("t2_rd_data", 64'(rd_data), 64'h0_4000_0011);
    cyc(1, fl(HT, 30'h44), 0);
    cyc(1, fl(BODY, 30'h55), 0);
    cyc(0, '0, 0);
    @(negedge clk);
    chk("t3_count", 64'(cnt), 64'd4);
    chk("t3_rdy", 64'(rdy), 64'd0);
    chk("t3_pkt", 64'(pkt), 64'd2);
    cyc(1, fl(BODY, 30'h66), 1);
    cyc(0, '0, 1);
    @(negedge clk);
    chk("t4_count", 64'(cnt), 64'd3);
    chk("t4_pop1", 64'(rd_data), 64'h0_8000_0022);
    cyc(0, '0, 1);
    @(negedge clk);
    chk("t4_pop2", 64'(rd_data), 64'h0_C000_0033);
    cyc(0, '0, 1);
    @(negedge clk);
    chk("t4_pop3", 64'(rd_data), 64'h1_0000_0044);
    cyc(0, '0, 0);
    @(negedge clk);
    chk("t4_empty", 64'(cnt), 64'd0);
    chk("t4_pkt", 64'(pkt), 64'd0);
    streaming = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1, fl(BODY, 30'(100 + i)), 1);
    repeat (3) cyc(0, '0, 1);
    cyc(0, '0, 0);
    @(negedge clk);
    streaming = 1'b0;
    chk("t5_obs_len", 64'(obs_q.size()), 64'd10);
    foreach (obs_q[i]) chk("t5_order", 64'(obs_q[i]), 64'h0_8000_0000 + 64'(100 + i));
    cyc(1, fl(HEAD, 30'h77), 0);
    cyc(1, fl(TAIL, 30'h88), 0);
    cyc(0, '0, 0);
    @(negedge clk);
    chk("t6_count_pre", 64'(cnt), 64'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_count", 64'(cnt), 64'd0);
    chk("t6_vld", 64'(vld), 64'd0);
    chk("t6_pkt", 64'(pkt), 64'd0);
    chk("t6_rd_data", 64'(rd_data), 64'd0);
    #4 rst_n = 1'b1;
    cyc(0, '0, 1);
    cyc(0, '0, 1);
    cyc(0, '0, 0);
    @(negedge clk);
    chk("t6_after_vld", 64'(vld), 64'd0);
    chk("t6_after_count", 64'(cnt), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
